regfile_mp: RTL

- Parametrised multi-port general-purpose register file; successor to the 2-read/1-write CPU register file.
- Sits between the decode stage (read ports) and the write-back stages (write ports), with N read ports and M write ports.
- Adds a post-reset hardware clear sequencer with a busy flag, deterministic write-conflict priority, and optional write-to-read bypass.
- Register 0 is hard-wired zero.

---
 rtl/regfile_mp_if.sv | 26 ++
 rtl/regfile_mp.sv | 101 ++++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write ports, read ports and the clear-busy flag.
// master = decode/write-back side, slave = register file.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
);
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] waddr;
  logic [NUM_WR*DATA_W-1:0] wdata;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     init_busy;

  modport master (
    output we, waddr, wdata, re, raddr,
    input  rdata, init_busy
  );

  modport slave (
    input  we, waddr, wdata, re, raddr,
    output rdata, init_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset clear sequencer; register 0 reads zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int unsigned NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREG - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic              clr_en;
  logic              wr_en;
  logic              init_busy_c;
  logic [NUM_RD*DATA_W-1:0] rdata_c;

  logic [DATA_W-1:0] regs [NREG];

  // State register and clear pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= ADDR_W'(1);
    end else begin
      state <= state_nxt;
      if (clr_en) clr_ptr <= clr_ptr + ADDR_W'(1);
    end
  end

  // Next-state logic: leave CLEAR once the last register is being cleared
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_ptr == LAST_ADDR) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  // Output decode
  always_comb begin
    init_busy_c = 1'b0;
    clr_en      = 1'b0;
    wr_en       = 1'b0;
    case (state)
      CLEAR: begin
        init_busy_c = 1'b1;
        clr_en      = 1'b1;
      end
      READY:   wr_en = 1'b1;
      default: init_busy_c = 1'b1;
    endcase
  end

  // Array update; ascending port loop lets the highest-indexed port win a conflict
  always_ff @(posedge clk) begin
    if (clr_en) begin
      regs[clr_ptr] <= '0;
    end else if (wr_en) begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (bus.we[k] && (bus.waddr[k*ADDR_W +: ADDR_W] != '0))
          regs[bus.waddr[k*ADDR_W +: ADDR_W]] <= bus.wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // Combinational read ports
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    rdata_c = '0;
    ra      = '0;
    val     = '0;
    for (int unsigned j = 0; j < NUM_RD; j++) begin
      ra  = bus.raddr[j*ADDR_W +: ADDR_W];
      val = regs[ra];
`ifdef REGFILE_BYPASS_EN
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (bus.we[k] && (bus.waddr[k*ADDR_W +: ADDR_W] == ra))
          val = bus.wdata[k*DATA_W +: DATA_W];
      end
`endif
      if (!rst && (state == READY) && (ra != '0) && bus.re[j])
        rdata_c[j*DATA_W +: DATA_W] = val;
    end
  end

  assign bus.rdata     = rdata_c;
  assign bus.init_busy = init_busy_c;

endmodule
